// File: rtl/tm_inference_seq.sv
// Purpose : clause-serial Tsetlin Machine inference for one class; thresholded signed clause vote.
// Latency : out_valid rises K = N_CLAUSE/CL_PER_CYC cycles after the accept edge; initiation interval >= K+2.
// Backpr. : in_ready/cfg_ready high only in IDLE; verdict held in DONE until out_ready, no same-cycle re-accept.
//
// Ports: clk, rst (sync, active-high); cfg_we/cfg_addr/cfg_mask/cfg_ready load per-clause exclude masks;
//        in_valid/in_ready/features accept a feature vector; out_valid/out_ready/verdict return the decision.
// Option: define TM_SCORE_OUT_EN to add score_out (signed final score, valid with out_valid, 0 on reset).
module tm_inference_seq #(
    parameter int N_FEAT     = 2,
    parameter int N_CLAUSE   = 4,
    parameter int CL_PER_CYC = 1,
    parameter int THRESH     = 1,
    localparam int L  = 2 * N_FEAT,
    localparam int AW = $clog2(N_CLAUSE),
    localparam int SW = $clog2(N_CLAUSE / 2 + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [L-1:0]         cfg_mask,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_FEAT-1:0]    features,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 verdict
`ifdef TM_SCORE_OUT_EN
    ,
    output logic signed [SW-1:0] score_out
`endif
);

    localparam int K    = N_CLAUSE / CL_PER_CYC;
    localparam int GW   = (K > 1) ? $clog2(K) : 1;
    localparam int HALF = N_CLAUSE / 2;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                state_q, state_d;
    logic [N_FEAT-1:0]     feat_q;
    logic [L-1:0]          lit;
    logic [L-1:0]          mask_q [N_CLAUSE];
    logic signed [SW-1:0]  score_q;
    logic signed [SW-1:0]  delta;
    logic signed [SW-1:0]  score_nxt;
    logic [GW-1:0]         g_q;
    logic                  last_grp;
    logic                  verdict_q;
    logic                  accept;
    logic                  addr_ok;
    logic [L-1:0]          cm;
    logic                  hit;
    int                    j;

    // Positive literals in the low half, negated literals in the high half.
    assign lit = {~feat_q, feat_q};

    // Vote of the clause group selected by g_q. Excluded literals are forced
    // true in the AND; a fully excluded clause is forced false.
    always_comb begin
        delta = '0;
        cm    = '0;
        hit   = 1'b0;
        j     = 0;
        for (int c = 0; c < CL_PER_CYC; c++) begin
            j   = int'(g_q) * CL_PER_CYC + c;
            cm  = mask_q[AW'(j)];
            hit = (&(lit | cm)) & ~(&cm);
            if (hit) begin
                if (j < HALF)
                    delta = delta + SW'(1);
                else
                    delta = delta - SW'(1);
            end
        end
    end

    assign score_nxt = score_q + delta;
    assign last_grp  = (g_q == GW'(K - 1));
    assign accept    = in_valid & in_ready;

    // Addresses beyond the clause bank are ignored; with a power-of-two bank
    // every encodable address is valid.
    generate
        if ((2 ** AW) > N_CLAUSE) begin : g_addr_chk
            localparam logic [AW-1:0] NCA = AW'(N_CLAUSE);
            assign addr_ok = (cfg_addr < NCA);
        end else begin : g_addr_all
            assign addr_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid)
                    state_d = EVAL;
            end
            EVAL: begin
                if (last_grp)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q    <= '0;
            score_q   <= '0;
            g_q       <= '0;
            verdict_q <= 1'b0;
            for (int i = 0; i < N_CLAUSE; i++)
                mask_q[i] <= '1;
        end else begin
            // A write in the accept cycle lands before the first clause group
            // is evaluated, so the new mask applies to this transaction.
            if (cfg_we && cfg_ready && addr_ok)
                mask_q[cfg_addr] <= cfg_mask;
            if (accept) begin
                feat_q  <= features;
                score_q <= '0;
                g_q     <= '0;
            end else if (state_q == EVAL) begin
                score_q <= score_nxt;
                g_q     <= g_q + GW'(1);
                if (last_grp)
                    verdict_q <= (int'(score_nxt) >= THRESH);
            end
        end
    end

    assign verdict = verdict_q;

`ifdef TM_SCORE_OUT_EN
    logic signed [SW-1:0] score_out_q;

    always_ff @(posedge clk) begin
        if (rst)
            score_out_q <= '0;
        else if (state_q == EVAL && last_grp)
            score_out_q <= score_nxt;
    end

    assign score_out = score_out_q;
`endif

endmodule

// File: tb/tb_tm_inference_seq.sv
module tb_tm_inference_seq;

    localparam int NF = 2;
    localparam int NC = 4;
    localparam int TH = 1;
    localparam int K1 = 4;
    localparam int K2 = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_mask;
    logic       cfg_ready, cfg_ready2;
    logic       in_valid;
    logic       in_ready, in_ready2;
    logic [1:0] features;
    logic       out_valid, out_valid2;
    logic       out_ready;
    logic       verdict, verdict2;
`ifdef TM_SCORE_OUT_EN
    logic signed [2:0] score_out, score_out2;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] mm [NC];

    always #5 clk = ~clk;

    tm_inference_seq #(.N_FEAT(NF), .N_CLAUSE(NC), .CL_PER_CYC(1), .THRESH(TH)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .features(features),
        .out_valid(out_valid), .out_ready(out_ready), .verdict(verdict)
`ifdef TM_SCORE_OUT_EN
        , .score_out(score_out)
`endif
    );

    // Two clauses per cycle; shares every input so it runs in lockstep.
    tm_inference_seq #(.N_FEAT(NF), .N_CLAUSE(NC), .CL_PER_CYC(2), .THRESH(TH)) dut2 (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready2),
        .in_valid(in_valid), .in_ready(in_ready2), .features(features),
        .out_valid(out_valid2), .out_ready(out_ready), .verdict(verdict2)
`ifdef TM_SCORE_OUT_EN
        , .score_out(score_out2)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Score from the clause rules: each clause is the AND of its included
    // literals, x_i for bit i and ~x_i for bit NF+i; all-excluded clause is 0.
    function automatic int model_score(input logic [NF-1:0] f);
        int s = 0;
        for (int c = 0; c < NC; c++) begin
            bit   fires;
            bit   any_incl;
            logic lv;
            fires    = 1;
            any_incl = 0;
            for (int b = 0; b < 2 * NF; b++) begin
                if (mm[c][b] == 1'b0) begin
                    any_incl = 1;
                    lv = (b < NF) ? f[b] : ~f[b - NF];
                    if (lv == 1'b0) fires = 0;
                end
            end
            if (fires && any_incl) s += (c < NC / 2) ? 1 : -1;
        end
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NC; i++) mm[i] = 4'b1111;
    endtask

    task automatic cfg_write(input int a, input logic [3:0] m);
        cfg_we   = 1'b1;
        cfg_addr = a[1:0];
        cfg_mask = m;
        check("cfg_ready_idle", cfg_ready, 1);
        if (cfg_ready && a < NC) mm[a] = m;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] f, input int hold, input bit noise,
                           input bit cfg_at_acc, input int ca, input logic [3:0] cmk);
        int n;
        int n2;
        int es;
        check("in_ready_idle", in_ready, 1);
        features = f;
        in_valid = 1'b1;
        if (cfg_at_acc) begin
            cfg_we   = 1'b1;
            cfg_addr = ca[1:0];
            cfg_mask = cmk;
            mm[ca]   = cmk;
        end
        es = model_score(f);
        tick;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        n  = 0;
        n2 = -1;
        while (!out_valid && n < 40) begin
            if (out_valid2 && n2 < 0) n2 = n;
            check("in_ready_busy", in_ready, 0);
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                features = 2'($urandom);
                cfg_we   = 1'($urandom_range(0, 1));
                cfg_addr = 2'($urandom);
                cfg_mask = 4'($urandom);
            end
            tick;
            n++;
        end
        if (out_valid2 && n2 < 0) n2 = n;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check("latency", n, K1);
        check("latency_cl2", n2, K2);
        check("verdict", verdict, int'(es >= TH));
        check("verdict_cl2", verdict2, int'(es >= TH));
`ifdef TM_SCORE_OUT_EN
        check("score_out", int'(score_out), es);
        check("score_out_cl2", int'(score_out2), es);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            features = 2'($urandom);
            tick;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_verdict", verdict, int'(es >= TH));
        end
        // in_valid stays high across the release edge; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        features  = 2'($urandom);
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready_cl2", in_ready2, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_mask  = '0;
        in_valid  = 1'b0;
        features  = '0;
        out_ready = 1'b0;
        model_reset();
        tick;
        tick;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_verdict", verdict, 0);
        check("rst_cfg_ready", cfg_ready, 1);
`ifdef TM_SCORE_OUT_EN
        check("rst_score_out", int'(score_out), 0);
`endif

        // Default all-ones masks: every clause silent.
        run_txn(2'b01, 0, 0, 0, 0, 4'b0000);

        cfg_write(0, 4'b0110);
        cfg_write(1, 4'b1001);
        cfg_write(2, 4'b1100);
        cfg_write(3, 4'b0011);
        run_txn(2'b01, 0, 0, 0, 0, 4'b0000);
        run_txn(2'b10, 0, 0, 0, 0, 4'b0000);
        run_txn(2'b11, 0, 0, 0, 0, 4'b0000);
        run_txn(2'b00, 0, 0, 0, 0, 4'b0000);

        // Stalled DONE with input noise, then config writes during EVAL.
        run_txn(2'b10, 5, 1, 0, 0, 4'b0000);
        run_txn(2'b01, 1, 1, 0, 0, 4'b0000);
        run_txn(2'b01, 0, 0, 0, 0, 4'b0000);

        // Config write in the accept cycle applies to that run.
        run_txn(2'b01, 0, 0, 1, 0, 4'b1111);
        cfg_write(0, 4'b0110);
        run_txn(2'b01, 0, 0, 0, 0, 4'b0000);

        // Reset mid-EVAL aborts and restores all-ones masks.
        features = 2'b01;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_reset();
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_cfg_ready", cfg_ready, 1);
        check("abort_out_valid_cl2", out_valid2, 0);
        run_txn(2'b01, 0, 0, 0, 0, 4'b0000);
        run_txn(2'b10, 0, 0, 0, 0, 4'b0000);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write(int'($urandom_range(0, NC - 1)), 4'($urandom));
            run_txn(2'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NC - 1)), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
